// File: rtl/hw3_p2.sv
// hw3_p2: registered WIDTH-bit ripple-carry adder.
// A chain of 1-bit full-adder cells feeds one output register stage.
// Outputs are exposed one clock after in_valid. The outputs are the sum,
// the carry out, every internal stage carry and the signed overflow flag.

// One full-adder cell: the stage of the ripple chain.
module hw3_p2_fa (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);
endmodule

module hw3_p2 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             in_valid,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic [WIDTH-1:0] carry,
    output logic             overflow,
    output logic             out_valid
);
    // c[0] is the carry-in. c[i+1] is the carry out of stage i.
    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] s_comb;

    assign c[0] = cin;

    // True ripple: each cell consumes the previous cell's carry.
    for (genvar i = 0; i < WIDTH; i++) begin : g_stage
        hw3_p2_fa u_fa (
            .a  (a[i]),
            .b  (b[i]),
            .ci (c[i]),
            .s  (s_comb[i]),
            .co (c[i+1])
        );
    end

    logic [WIDTH-1:0] sum_d,   sum_q;
    logic             cout_d,  cout_q;
    logic [WIDTH-1:0] carry_d, carry_q;
    logic             ovf_d,   ovf_q;
    logic             vld_d,   vld_q;

    // Next-state logic: load on a valid strobe, otherwise hold. The valid flag follows in_valid.
    always_comb begin
        sum_d   = sum_q;
        cout_d  = cout_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        vld_d   = in_valid;
        if (in_valid) begin
            sum_d   = s_comb;
            cout_d  = c[WIDTH];
            carry_d = c[WIDTH:1];
            // Signed overflow: carry into the MSB differs from the carry out of it.
            // For WIDTH=1, c[WIDTH-1] is cin.
            ovf_d   = c[WIDTH] ^ c[WIDTH-1];
        end
    end

    // Output registers. Reset wins over in_valid, so a same-cycle operand is dropped.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum_q   <= '0;
            cout_q  <= 1'b0;
            carry_q <= '0;
            ovf_q   <= 1'b0;
            vld_q   <= 1'b0;
        end else begin
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            vld_q   <= vld_d;
        end
    end

    assign sum       = sum_q;
    assign cout      = cout_q;
    assign carry     = carry_q;
    assign overflow  = ovf_q;
    assign out_valid = vld_q;
endmodule

// File: tb/tb_hw3_p2.sv
// Testbench for hw3_p2 (WIDTH=4). Directed spec vectors, boundaries,
// an exhaustive sweep, then random traffic against an arithmetic model.
module tb_hw3_p2;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] a, b;
    logic         cin, in_valid;
    logic [W-1:0] sum, carry;
    logic         cout, overflow, out_valid;

    int errors = 0;
    int checks = 0;

    // Expected register contents
    logic [W-1:0] e_sum, e_carry;
    logic         e_cout, e_ovf, e_vld;

    hw3_p2 #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .in_valid  (in_valid),
        .sum       (sum),
        .cout      (cout),
        .carry     (carry),
        .overflow  (overflow),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference built from integer addition. The carry out of stage i is
    // bit i+1 of the sum of the low i+1 bits of a and b plus cin.
    task automatic model(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                         input logic tc);
        int full, sa, sb, ss, lo;
        full  = int'(ta) + int'(tb_) + int'(tc);
        e_sum  = full[W-1:0];
        e_cout = full[W];
        for (int i = 0; i < W; i++) begin
            lo = (int'(ta) % (1 << (i+1))) + (int'(tb_) % (1 << (i+1))) + int'(tc);
            e_carry[i] = lo[i+1];
        end
        sa = (ta[W-1]) ? int'(ta) - (1 << W) : int'(ta);
        sb = (tb_[W-1]) ? int'(tb_) - (1 << W) : int'(tb_);
        ss = sa + sb + int'(tc);
        e_ovf = (ss > (1 << (W-1)) - 1) || (ss < -(1 << (W-1)));
    endtask

    // One clock: drive on the falling edge, update the model at the rising edge, check 1ns later.
    task automatic step(input logic r, input logic v, input logic [W-1:0] ta,
                        input logic [W-1:0] tb_, input logic tc, input string tag);
        @(negedge clk);
        rst_n = r; in_valid = v; a = ta; b = tb_; cin = tc;
        @(posedge clk);
        if (!r) begin
            e_sum = '0; e_cout = 0; e_carry = '0; e_ovf = 0; e_vld = 0;
        end else begin
            e_vld = v;
            if (v) model(ta, tb_, tc);
        end
        #1;
        chk({tag, ".sum"},   32'(sum),       32'(e_sum));
        chk({tag, ".cout"},  32'(cout),      32'(e_cout));
        chk({tag, ".carry"}, 32'(carry),     32'(e_carry));
        chk({tag, ".ovf"},   32'(overflow),  32'(e_ovf));
        chk({tag, ".vld"},   32'(out_valid), 32'(e_vld));
    endtask

    // Compare the current outputs with hand-derived values.
    task automatic lit(input string tag, input logic [3:0] s, input logic co,
                       input logic [3:0] cr, input logic ov, input logic vl);
        chk({tag, ".lit_sum"},   32'(sum),       32'(s));
        chk({tag, ".lit_cout"},  32'(cout),      32'(co));
        chk({tag, ".lit_carry"}, 32'(carry),     32'(cr));
        chk({tag, ".lit_ovf"},   32'(overflow),  32'(ov));
        chk({tag, ".lit_vld"},   32'(out_valid), 32'(vl));
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0;
        e_sum = '0; e_cout = 0; e_carry = '0; e_ovf = 0; e_vld = 0;

        // Reset with a valid operand present: the operand must be dropped.
        step(0, 1, 4'hF, 4'hF, 1, "rst0");
        lit("rst0", 4'h0, 0, 4'h0, 0, 0);
        step(0, 1, 4'hF, 4'hF, 1, "rst1");
        lit("rst1", 4'h0, 0, 4'h0, 0, 0);
        step(1, 0, 4'hF, 4'hF, 1, "idle0");
        lit("idle0", 4'h0, 0, 4'h0, 0, 0);
        step(1, 0, 4'h0, 4'h0, 0, "idle1");

        // Spec vectors. Vectors 3 and 4 are back-to-back.
        step(1, 1, 4'b0110, 4'b1010, 0, "v1");
        lit("v1", 4'b0000, 1, 4'b1110, 0, 1);
        step(1, 1, 4'b1001, 4'b1010, 1, "v2");
        lit("v2", 4'b0100, 1, 4'b1011, 1, 1);
        step(1, 1, 4'b0110, 4'b0101, 0, "v3");
        lit("v3", 4'b1011, 0, 4'b0100, 1, 1);
        step(1, 1, 4'b1001, 4'b0101, 1, "v4");
        lit("v4", 4'b1111, 0, 4'b0001, 0, 1);

        // Boundary cases
        step(1, 1, 4'hF, 4'hF, 1, "allones");
        lit("allones", 4'hF, 1, 4'hF, 0, 1);
        step(1, 1, 4'b0111, 4'b0000, 1, "posovf");
        lit("posovf", 4'b1000, 0, 4'b0111, 1, 1);
        // A dropped valid holds the data and clears out_valid.
        step(1, 0, 4'h3, 4'h3, 0, "hold");
        lit("hold", 4'b1000, 0, 4'b0111, 1, 0);

        // An accepted operand followed by reset: the reset edge clears the result.
        step(1, 1, 4'h5, 4'h6, 1, "prerst");
        step(0, 0, 4'h0, 4'h0, 0, "postrst");
        lit("postrst", 4'h0, 0, 4'h0, 0, 0);

        // Exhaustive sweep of all 512 (a, b, cin) combinations
        for (int i = 0; i < 512; i++) begin
            logic [8:0] vec;
            vec = 9'(i);
            step(1, 1, vec[3:0], vec[7:4], vec[8], "sweep");
        end

        // Random traffic with random valid gaps and occasional resets
        for (int i = 0; i < 300; i++) begin
            logic r, v;
            r = ($urandom_range(0, 19) != 0);
            v = ($urandom_range(0, 3) != 0);
            step(r, v, 4'($urandom), 4'($urandom), 1'($urandom), "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
